// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM controller with a one-entry posted write buffer and read-after-write bypass.
// Define AHB_SRAM_ERR_RESP_EN to answer oversize/misaligned accesses with a two-cycle ERROR.
module ahb_sram_ctrl #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      hclk,
    input  logic                      hrst_b,
    input  logic                      hsel,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [31:0]               haddr,
    input  logic [31:0]               hwdata,
    output logic [31:0]               hrdata,
    output logic                      hready,
    output logic                      hresp,
    output logic                      ram_cen,
    output logic [3:0]                ram_wen,
    output logic [MEM_ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]               ram_din,
    input  logic [31:0]               ram_dout
);
    localparam int AW = MEM_ADDR_WIDTH - 2;

    // state  | meaning
    // IDLE   | no data phase in progress
    // RDATA  | read data phase, waits while wait_cnt != 0
    // WDATA  | write data phase, hwdata captured into the buffer
    // ERR1   | first ERROR cycle (hready=0)
    // ERR2   | second ERROR cycle (hready=1), exits like IDLE
`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [2:0] {S_IDLE, S_RDATA, S_WDATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RDATA, S_WDATA} state_t;
`endif

    state_t         state;
    logic [1:0]     wait_cnt;
    logic           rd_first;
    logic [AW-1:0]  rd_addr_q;
    logic [AW-1:0]  wd_addr_q;
    logic [3:0]     wd_mask_q;
    logic [31:0]    rdata_q;
    logic           buf_valid;
    logic [AW-1:0]  buf_addr;
    logic [3:0]     buf_mask;
    logic [31:0]    buf_data;

    logic           accept;
    logic           bad_access;
    logic           rd_acc;
    logic           wr_acc;
    logic [3:0]     lane_mask;
    logic [AW-1:0]  word_addr;
    logic [31:0]    merged;
    logic           unused_bits;

    assign unused_bits = ^{htrans[0], haddr[31:MEM_ADDR_WIDTH]};
    assign word_addr   = haddr[MEM_ADDR_WIDTH-1:2];

`ifdef AHB_SRAM_ERR_RESP_EN
    assign hready     = (wait_cnt == 2'd0) && (state != S_ERR1);
    assign hresp      = (state == S_ERR1) || (state == S_ERR2);
    assign bad_access = (hsize > 3'd2) || ((hsize == 3'd1) && haddr[0]) ||
                        ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`else
    assign hready     = (wait_cnt == 2'd0);
    assign hresp      = 1'b0;
    assign bad_access = 1'b0;
`endif

    assign accept = hrst_b & hsel & hready & htrans[1];
    assign rd_acc = accept & ~hwrite & ~bad_access;
    assign wr_acc = accept & hwrite & ~bad_access;

    always_comb begin
        case (hsize)
            3'd0:    lane_mask = 4'b0001 << haddr[1:0];
            3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Lanes still sitting in the write buffer override the (stale) SRAM data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = (buf_valid && (buf_addr == rd_addr_q) && buf_mask[i]) ?
                               buf_data[8*i +: 8] : ram_dout[8*i +: 8];
        end
    end

    assign hrdata = ((state == S_RDATA) && (wait_cnt == 2'd0)) ?
                    (rd_first ? merged : rdata_q) : 32'd0;

    // Reads own the SRAM port in their address phase; otherwise the buffer drains.
    always_comb begin
        ram_cen  = 1'b0;
        ram_wen  = 4'b0000;
        ram_addr = buf_addr;
        ram_din  = buf_data;
        if (rd_acc) begin
            ram_cen  = 1'b1;
            ram_addr = word_addr;
        end else if (buf_valid) begin
            ram_cen = 1'b1;
            ram_wen = buf_mask;
        end
    end

    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state     <= S_IDLE;
            wait_cnt  <= 2'd0;
            rd_first  <= 1'b0;
            rd_addr_q <= '0;
            wd_addr_q <= '0;
            wd_mask_q <= 4'b0000;
            rdata_q   <= 32'd0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_mask  <= 4'b0000;
            buf_data  <= 32'd0;
        end else begin
            rd_first <= rd_acc;
            if (rd_first)
                rdata_q <= merged;

            if (wait_cnt != 2'd0)
                wait_cnt <= wait_cnt - 2'd1;
            else if (rd_acc)
                wait_cnt <= 2'(WAIT_STATES);

            if (rd_acc)
                rd_addr_q <= word_addr;
            if (wr_acc) begin
                wd_addr_q <= word_addr;
                wd_mask_q <= lane_mask;
            end

            if (state == S_WDATA) begin
                buf_valid <= 1'b1;
                buf_addr  <= wd_addr_q;
                buf_mask  <= wd_mask_q;
                buf_data  <= hwdata;
            end else if (buf_valid && !rd_acc) begin
                buf_valid <= 1'b0;
            end

`ifdef AHB_SRAM_ERR_RESP_EN
            if (state == S_ERR1)
                state <= S_ERR2;
            else
`endif
            if (hready) begin
                if (rd_acc)
                    state <= S_RDATA;
                else if (wr_acc)
                    state <= S_WDATA;
`ifdef AHB_SRAM_ERR_RESP_EN
                else if (accept)
                    state <= S_ERR1;
`endif
                else
                    state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: two instances (0 and 2 wait states), each with an SRAM model,
// checked every cycle against an architectural memory model plus directed literal checks.
module tb_ahb_sram_ctrl;
    localparam int NW     = 1024;
    localparam int K_NONE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_E1   = 3;
    localparam int K_E2   = 4;

    logic        hclk   = 1'b0;
    logic        hrst_b = 1'b0;
    logic        hsel   = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize  = 3'd0;
    logic [31:0] haddr  = 32'd0;
    logic [31:0] hwdata = 32'd0;
    int          tgt    = 0;

    logic [31:0] hrdata_v   [2];
    logic        hready_v   [2];
    logic        hresp_v    [2];
    logic        ram_cen_v  [2];
    logic [3:0]  ram_wen_v  [2];
    logic [9:0]  ram_addr_v [2];
    logic [31:0] ram_din_v  [2];
    logic [31:0] ram_dout_v [2];

    int n_err    = 0;
    int n_checks = 0;

    logic [31:0] s_rdata;
    logic        s_rdy, s_resp, s_cen;

    int          dp_kind [2];
    int          dp_wait [2];
    logic [31:0] dp_addr [2];
    logic [3:0]  dp_mask [2];
    logic [31:0] amem    [2][NW];
    bit          m_init = 1'b0;

    always #5 hclk = ~hclk;

    function automatic logic [31:0] init_word(int i);
        case (i)
            0:       return 32'hCAFE1234;
            12:      return 32'h55667788;
            16:      return 32'h0BADF00D;
            25:      return 32'h99887766;
            default: return {i[15:0] ^ 16'h5A5A, i[15:0]};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] sram [NW];
        bit          loaded = 1'b0;

        ahb_sram_ctrl #(.MEM_ADDR_WIDTH(12), .WAIT_STATES(2 * g)) u_dut (
            .hclk     (hclk),
            .hrst_b   (hrst_b),
            .hsel     (hsel && (tgt == g)),
            .htrans   (htrans),
            .hwrite   (hwrite),
            .hsize    (hsize),
            .haddr    (haddr),
            .hwdata   (hwdata),
            .hrdata   (hrdata_v[g]),
            .hready   (hready_v[g]),
            .hresp    (hresp_v[g]),
            .ram_cen  (ram_cen_v[g]),
            .ram_wen  (ram_wen_v[g]),
            .ram_addr (ram_addr_v[g]),
            .ram_din  (ram_din_v[g]),
            .ram_dout (ram_dout_v[g])
        );

        always @(posedge hclk) begin
            if (!loaded) begin
                for (int i = 0; i < NW; i++) sram[i] <= init_word(i);
                loaded <= 1'b1;
            end else if (ram_cen_v[g]) begin
                if (ram_wen_v[g] == 4'd0)
                    ram_dout_v[g] <= sram[ram_addr_v[g]];
                else
                    for (int b = 0; b < 4; b++)
                        if (ram_wen_v[g][b])
                            sram[ram_addr_v[g]][8*b +: 8] <= ram_din_v[g][8*b +: 8];
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: a read returns the memory as left by all earlier completed writes.
    task automatic model_step();
        if (!m_init) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < NW; i++) amem[g][i] = init_word(i);
                dp_kind[g] = K_NONE;
                dp_wait[g] = 0;
            end
            m_init = 1'b1;
        end
        for (int g = 0; g < 2; g++) begin
            logic [31:0] e_rd;
            logic        e_rdy, e_resp;
            int          nbytes, off;
            bit          bad;
            e_rd = 32'd0; e_rdy = 1'b1; e_resp = 1'b0;
            if (hrst_b) begin
                case (dp_kind[g])
                    K_RD: begin
                        e_rdy = (dp_wait[g] == 0);
                        if (e_rdy) e_rd = amem[g][dp_addr[g][11:2]];
                    end
                    K_E1: begin e_rdy = 1'b0; e_resp = 1'b1; end
                    K_E2: e_resp = 1'b1;
                    default: ;
                endcase
            end else begin
                chk($sformatf("rst_cen[%0d]", g), 32'(ram_cen_v[g]), 32'd0);
                chk($sformatf("rst_wen[%0d]", g), 32'(ram_wen_v[g]), 32'd0);
            end
            chk($sformatf("hready[%0d]", g), 32'(hready_v[g]), 32'(e_rdy));
            chk($sformatf("hresp[%0d]", g), 32'(hresp_v[g]), 32'(e_resp));
            chk($sformatf("hrdata[%0d]", g), hrdata_v[g], e_rd);

            if (!hrst_b) begin
                dp_kind[g] = K_NONE;
                dp_wait[g] = 0;
            end else begin
                if (dp_kind[g] == K_WR)
                    for (int b = 0; b < 4; b++)
                        if (dp_mask[g][b]) amem[g][dp_addr[g][11:2]][8*b +: 8] = hwdata[8*b +: 8];
                if (dp_kind[g] == K_E1) begin
                    dp_kind[g] = K_E2;
                end else if (!e_rdy) begin
                    dp_wait[g]--;
                end else if (hsel && (tgt == g) && htrans[1]) begin
                    nbytes = (hsize > 3'd2) ? 4 : (1 << hsize);
                    off    = (int'(haddr[1:0]) / nbytes) * nbytes;
                    bad    = 1'b0;
`ifdef AHB_SRAM_ERR_RESP_EN
                    bad = (hsize > 3'd2) || ((int'(haddr[1:0]) % nbytes) != 0);
`endif
                    dp_addr[g] = haddr;
                    dp_mask[g] = 4'(((1 << nbytes) - 1) << off);
                    dp_wait[g] = 0;
                    if (bad) dp_kind[g] = K_E1;
                    else if (hwrite) dp_kind[g] = K_WR;
                    else begin
                        dp_kind[g] = K_RD;
                        dp_wait[g] = 2 * g;
                    end
                end else begin
                    dp_kind[g] = K_NONE;
                end
            end
        end
    endtask

    task automatic cyc(bit rst, bit sel, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        @(posedge hclk);
        #1;
        hrst_b = !rst;
        hsel   = sel;
        htrans = sel ? 2'b10 : 2'b00;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        @(negedge hclk);
        model_step();
        s_rdata = hrdata_v[tgt];
        s_rdy   = hready_v[tgt];
        s_resp  = hresp_v[tgt];
        s_cen   = ram_cen_v[tgt];
    endtask

    task automatic rd_wait(input logic [31:0] wd, output int lows, output bit done);
        lows = 0;
        done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 3'd0, 32'd0, (k == 0) ? wd : 32'd0);
            if (s_rdy) begin
                done = 1'b1;
                break;
            end
            lows++;
        end
    endtask

    initial begin
        int  lows;
        bit  done;
        tgt = 0;
        cyc(1, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(1, 1, 0, 3'd2, 32'h10, 32'd0);
        chk("reset_hready", 32'(s_rdy), 32'd1);
        chk("reset_hrdata", s_rdata, 32'd0);
        chk("reset_cen", 32'(s_cen), 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);

        // write then read same word back-to-back: bypass, no wait
        lows = 0;
        cyc(0, 1, 1, 3'd2, 32'h010, 32'd0);         lows += int'(!s_rdy);
        cyc(0, 1, 0, 3'd2, 32'h010, 32'hDEADBEEF);  lows += int'(!s_rdy);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);           lows += int'(!s_rdy);
        chk("raw_bypass", s_rdata, 32'hDEADBEEF);
        chk("raw_no_wait", 32'(lows), 32'd0);

        // word write, byte write into lane 1, idle, read back
        cyc(0, 1, 1, 3'd2, 32'h020, 32'd0);
        cyc(0, 1, 1, 3'd0, 32'h021, 32'h11223344);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'hAAAAAAAA);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h020, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("byte_merge", s_rdata, 32'h1122AA44);

        // byte write immediately followed by word read: lane-wise bypass merge
        cyc(0, 1, 1, 3'd0, 32'h051, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h050, 32'h77777777);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("partial_bypass", s_rdata, 32'h5A4E7714);

        // read of another word while a write is buffered, then read of the buffered word
        cyc(0, 1, 1, 3'd2, 32'h060, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h064, 32'h01020304);
        cyc(0, 1, 0, 3'd2, 32'h060, 32'd0);
        chk("nohit_read", s_rdata, 32'h99887766);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("hit_read", s_rdata, 32'h01020304);

        // upper halfword write
        cyc(0, 1, 1, 3'd1, 32'h006, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'h12345678);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h004, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("half_upper", s_rdata, 32'h12340001);

        // misaligned halfword read at 0x003
        cyc(0, 1, 0, 3'd1, 32'h003, 32'd0);
`ifdef AHB_SRAM_ERR_RESP_EN
        chk("err_addr_cen", 32'(s_cen), 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("err1_resp", 32'(s_resp), 32'd1);
        chk("err1_ready", 32'(s_rdy), 32'd0);
        chk("err1_cen", 32'(s_cen), 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("err2_resp", 32'(s_resp), 32'd1);
        chk("err2_ready", 32'(s_rdy), 32'd1);
        chk("err2_cen", 32'(s_cen), 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("err_done_resp", 32'(s_resp), 32'd0);
`else
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("misalign_data", s_rdata, 32'hCAFE1234);
        chk("misalign_resp", 32'(s_resp), 32'd0);
`endif

        // reset during a halfword write's data phase discards the write
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 1, 1, 3'd1, 32'h032, 32'd0);
        cyc(1, 0, 0, 3'd0, 32'd0, 32'hBEEFBEEF);
        chk("rst_mid_ready", 32'(s_rdy), 32'd1);
        chk("rst_mid_rdata", s_rdata, 32'd0);
        cyc(1, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h030, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        chk("rst_discard", s_rdata, 32'h55667788);

        // two wait-state instance
        tgt = 1;
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h040, 32'd0);
        rd_wait(32'd0, lows, done);
        chk("ws2_done", 32'(done), 32'd1);
        chk("ws2_lows", 32'(lows), 32'd2);
        chk("ws2_data", s_rdata, 32'h0BADF00D);

        cyc(0, 1, 1, 3'd2, 32'h044, 32'd0);
        cyc(0, 1, 0, 3'd2, 32'h044, 32'hFEEDC0DE);
        rd_wait(32'd0, lows, done);
        chk("ws2_byp_done", 32'(done), 32'd1);
        chk("ws2_byp_lows", 32'(lows), 32'd2);
        chk("ws2_byp_data", s_rdata, 32'hFEEDC0DE);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
